// File: rtl/ica_iter_sequencer.sv
// FastICA iteration sequencer: arms update and orth stages, then checks convergence.
// Define ICA_SEQ_TIMEOUT_EN to build the per-stage busy watchdog and the ERR path.
module ica_iter_sequencer #(
    parameter logic [6:0] MAX_ITER   = 7'd100,
    parameter logic [2:0] ARM_CYCLES = 3'd2,
    parameter logic [7:0] TIMEOUT    = 8'd127
) (
    input  logic       clk_ica,
    input  logic       go_ica,
    input  logic       start,
    input  logic       conv_valid,
    input  logic       conv_flag,
    input  logic       upd_busy,
    input  logic       symm_busy,
    output logic       go_upd,
    output logic       go_symm,
    output logic       ica_busy,
    output logic       ica_done,
    output logic       max_hit,
    output logic       timeout_err,
    output logic [6:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE, ARM_UPD, RUN_UPD, ARM_SYMM,
        RUN_SYMM, CHECK, DONE, ERR
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] arm_cnt_q, arm_cnt_d;
    logic [6:0] iter_q, iter_d;
    logic       max_q, max_d;
    logic       go_upd_q, go_symm_q;
    logic       busy_q, done_q;
    logic       wd_exp;

`ifdef ICA_SEQ_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       terr_q;

    assign wd_exp = (wd_q == TIMEOUT);

    // Counter is zero whenever a RUN state is entered.
    always_comb begin
        wd_d = 8'd0;
        if ((state_q == RUN_UPD || state_q == RUN_SYMM) &&
            state_d == state_q)
            wd_d = wd_q + 8'd1;
    end

    always_ff @(posedge clk_ica or negedge go_ica) begin
        if (!go_ica) begin
            wd_q   <= 8'd0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= (state_d == ERR);
        end
    end

    assign timeout_err = terr_q;
`else
    assign wd_exp      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        iter_d    = iter_q;
        max_d     = max_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = ARM_UPD;
                    iter_d  = 7'd0;
                    max_d   = 1'b0;
                end
            end
            ARM_UPD, ARM_SYMM: begin
                if (arm_cnt_q == ARM_CYCLES - 3'd1) begin
                    arm_cnt_d = 3'd0;
                    state_d   = (state_q == ARM_UPD) ? RUN_UPD
                                                     : RUN_SYMM;
                end else begin
                    arm_cnt_d = arm_cnt_q + 3'd1;
                end
            end
            RUN_UPD: begin
                if (!upd_busy)
                    state_d = ARM_SYMM;
                else if (wd_exp)
                    state_d = ERR;
            end
            RUN_SYMM: begin
                if (!symm_busy) begin
                    state_d = CHECK;
                    iter_d  = iter_q + 7'd1;
                end else if (wd_exp) begin
                    state_d = ERR;
                end
            end
            CHECK: begin
                if (conv_valid) begin
                    if (conv_flag) begin
                        state_d = DONE;
                    end else if (iter_q >= MAX_ITER) begin
                        state_d = DONE;
                        max_d   = 1'b1;
                    end else begin
                        state_d = ARM_UPD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_ica or negedge go_ica) begin
        if (!go_ica) begin
            state_q   <= IDLE;
            arm_cnt_q <= 3'd0;
            iter_q    <= 7'd0;
            max_q     <= 1'b0;
            go_upd_q  <= 1'b0;
            go_symm_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            iter_q    <= iter_d;
            max_q     <= max_d;
            go_upd_q  <= (state_d == RUN_UPD);
            go_symm_q <= (state_d == RUN_SYMM);
            busy_q    <= (state_d != IDLE) && (state_d != DONE) &&
                         (state_d != ERR);
            done_q    <= (state_d == DONE);
        end
    end

    assign go_upd   = go_upd_q;
    assign go_symm  = go_symm_q;
    assign ica_busy = busy_q;
    assign ica_done = done_q;
    assign max_hit  = max_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_ica_iter_sequencer.sv
// Randomized bench for ica_iter_sequencer against a run-level model.
// Watchdog expectations follow ICA_SEQ_TIMEOUT_EN.
module tb_ica_iter_sequencer;

    localparam int MI = 7;
    localparam int AC = 2;
    localparam int TO = 10;

    logic       clk_ica = 1'b0;
    logic       go_ica = 1'b1;
    logic       start = 1'b0;
    logic       conv_valid = 1'b0;
    logic       conv_flag = 1'b0;
    logic       upd_busy = 1'b1;
    logic       symm_busy = 1'b1;
    logic       go_upd, go_symm, ica_busy, ica_done;
    logic       max_hit, timeout_err;
    logic [6:0] iter_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ica_iter_sequencer #(
        .MAX_ITER   (7'(MI)),
        .ARM_CYCLES (3'(AC)),
        .TIMEOUT    (8'(TO))
    ) dut (
        .clk_ica     (clk_ica),
        .go_ica      (go_ica),
        .start       (start),
        .conv_valid  (conv_valid),
        .conv_flag   (conv_flag),
        .upd_busy    (upd_busy),
        .symm_busy   (symm_busy),
        .go_upd      (go_upd),
        .go_symm     (go_symm),
        .ica_busy    (ica_busy),
        .ica_done    (ica_done),
        .max_hit     (max_hit),
        .timeout_err (timeout_err),
        .iter_cnt    (iter_cnt)
    );

    always #5 clk_ica = ~clk_ica;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ica);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_go_upd"}, go_upd, 0);
        chk({tag, "_go_symm"}, go_symm, 0);
        chk({tag, "_busy"}, ica_busy, 0);
        chk({tag, "_done"}, ica_done, 0);
        chk({tag, "_max"}, max_hit, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_iter"}, iter_cnt, 0);
    endtask

    task automatic do_reset();
        go_ica = 1'b0;
        tick();
        go_ica = 1'b1;
        tick();
    endtask

    // Entered just after the edge that starts ARM_x.
    // Stage reports busy while held and for dur cycles of running.
    task automatic stage(input bit symm, input int dur);
        string nm;
        nm = symm ? "symm" : "upd";
        for (int i = 0; i < AC; i++) begin
            chk({"arm_low_", nm}, symm ? go_symm : go_upd, 0);
            if (symm && $urandom_range(0, 1) == 1) begin
                conv_valid = 1'b1;
                conv_flag  = 1'b1;
            end
            tick();
            conv_valid = 1'b0;
            conv_flag  = 1'b0;
        end
        chk({"go_rise_", nm}, symm ? go_symm : go_upd, 1);
        for (int i = 0; i < dur; i++) begin
            if (!symm && $urandom_range(0, 3) == 0)
                start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk({"run_hold_", nm}, symm ? go_symm : go_upd, 1);
        if (symm) symm_busy = 1'b0;
        else      upd_busy  = 1'b0;
        tick();
        symm_busy = 1'b1;
        upd_busy  = 1'b1;
        chk({"go_fall_", nm}, symm ? go_symm : go_upd, 0);
        chk({"run_busy_", nm}, ica_busy, 1);
    endtask

    // conv_at: first iteration whose check reports convergence.
    task automatic do_run(input int conv_at, input int fixed_dur);
        int  exp_iters;
        bit  exp_max;
        bit  last;
        int  d;
        exp_iters = (conv_at < MI) ? conv_at : MI;
        exp_max   = (conv_at > MI);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", ica_busy, 1);
        chk("start_done", ica_done, 0);
        chk("start_iter", iter_cnt, 0);
        chk("start_max", max_hit, 0);
        for (int it = 1; it <= MI; it++) begin
            stage(0, fixed_dur >= 0 ? fixed_dur : $urandom_range(0, TO));
            stage(1, fixed_dur >= 0 ? fixed_dur : $urandom_range(0, TO));
            chk("check_iter", iter_cnt, it);
            d = $urandom_range(0, 3);
            repeat (d) begin
                conv_flag = $urandom_range(0, 1) == 1;
                tick();
            end
            conv_valid = 1'b1;
            conv_flag  = (it == conv_at);
            start      = $urandom_range(0, 1) == 1;
            tick();
            conv_valid = 1'b0;
            conv_flag  = 1'b0;
            start      = 1'b0;
            last = (it == exp_iters);
            chk("res_done", ica_done, last);
            chk("res_busy", ica_busy, !last);
            if (last) break;
            chk("rearm_upd", go_upd, 0);
        end
        chk("final_iter", iter_cnt, exp_iters);
        chk("final_max", max_hit, exp_max);
        tick();
        chk("done_hold", ica_done, 1);
        chk("done_go_upd", go_upd, 0);
        chk("done_go_symm", go_symm, 0);
    endtask

    task automatic wd_test();
        start = 1'b1;
        tick();
        start = 1'b0;
        stage(0, 3);
        for (int i = 0; i < AC; i++) tick();
        chk("wd_go_rise", go_symm, 1);
`ifdef ICA_SEQ_TIMEOUT_EN
        begin
            int cnt;
            cnt = 0;
            while (!timeout_err && cnt < 40) begin
                tick();
                cnt++;
            end
            chk("wd_latency", cnt, TO + 1);
            chk("wd_terr", timeout_err, 1);
            chk("wd_go_upd", go_upd, 0);
            chk("wd_go_symm", go_symm, 0);
            chk("wd_busy", ica_busy, 0);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("wd_clr_terr", timeout_err, 0);
            chk("wd_restart_busy", ica_busy, 1);
        end
`else
        begin
            bit seen;
            seen = 1'b0;
            repeat (1000) begin
                tick();
                if (timeout_err !== 1'b0 || go_symm !== 1'b1)
                    seen = 1'b1;
            end
            chk("stuck_run", seen, 0);
            chk("stuck_busy", ica_busy, 1);
        end
`endif
        do_reset();
    endtask

    task automatic abort_test();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int it = 1; it <= 4; it++) begin
            stage(0, $urandom_range(0, TO));
            stage(1, $urandom_range(0, TO));
            conv_valid = 1'b1;
            tick();
            conv_valid = 1'b0;
        end
        stage(0, 2);
        for (int i = 0; i < AC; i++) tick();
        tick();
        chk("abort_pre_iter", iter_cnt, 4);
        chk("abort_pre_go", go_symm, 1);
        #2;
        go_ica = 1'b0;
        #1;
        chk_all_zero("abort");
        tick();
        go_ica = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_restart_iter", iter_cnt, 0);
        chk("abort_restart_busy", ica_busy, 1);
        do_reset();
    endtask

    initial begin
        #2;
        go_ica = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        go_ica = 1'b1;
        tick();
        chk_all_zero("idle");
        do_run(1, 6);
        do_run(MI + 5, -1);
        for (int r = 0; r < 6; r++)
            do_run($urandom_range(1, MI + 2), -1);
        do_run(2, TO);
        wd_test();
        abort_test();
        do_run($urandom_range(1, MI), -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
